branch_resolution_unit: RTL and testbench
=========================================

Name: branch_resolution_unit

Overview:
- Closes the loop on the bimodal branch predictor. ID pushes each decoded branch's prediction record into an in-order queue. MEM resolves the oldest branch.
- On resolution the block trains a table of 2-bit saturating counters and detects mispredictions. It issues a one-cycle flush/redirect to the fetch stage.
- Owns the counter table. The fetch-side lookup read port reads it.

Parameters:
- INDEX_BITS, 6, counter table index width (2^INDEX_BITS entries, indexed by pc[INDEX_BITS+1:2]).
- QUEUE_DEPTH, 4, in-flight branch records, power of 2.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- lookup_pc  in  64  IF-stage PC.
- lookup_taken  out  1  counter[idx(lookup_pc)][1], combinational read of current state.
- push_valid  in  1  ID has decoded a branch.
- push_ready  out  1  queue not full.
- push_pc  in  64  branch PC.
- push_pred  in  1  prediction used at fetch.
- resolve_valid  in  1  MEM stage holds a resolved branch.
- resolve_taken  in  1  actual outcome (Branch & zero).
- resolve_target  in  64  computed taken target.
- flush  out  1  registered one-cycle pulse, kill IF/ID/EX.
- redirect_pc  out  64  registered fetch PC, valid while flush=1.
- q_count  out  3  occupancy, 0..QUEUE_DEPTH.
- err_overflow  out  1  sticky: push while full.
- err_underflow  out  1  sticky: resolve while empty.
- stat_branches  out  CNT_W  resolved branches, saturating.
- stat_mispredicts  out  CNT_W  mispredictions, saturating.

Behaviour:
- Reset (sync, highest priority):
  - all counters become 2'b01 (weakly not-taken); reset takes 2^INDEX_BITS cycles via an INIT state sweeping the index.
  - push_ready=0 and lookup_taken=0 during INIT.
  - queue empty; flush=0, redirect_pc=0, err_*=0, stats=0.
  - reset asserted mid-operation discards all queue contents and restarts INIT.
- FSM:
  - INIT: sweep the index; after the last index go to RUN.
  - RUN: normal operation.
  - FLUSH: exactly one cycle after a misprediction, then back to RUN.
  - Pushes are ignored in FLUSH (wrong-path); resolves are accepted.
- Push:
  - Accepted when push_valid & push_ready. Stores {pc, pred} at the tail.
  - Push while full: ignored, err_overflow set.
- Resolve (resolve_valid in RUN/FLUSH):
  - Pop the head record.
  - Counter update at idx(head.pc): saturating, +1 if taken (max 2'b11), -1 if not (min 2'b00).
  - stat_branches increments.
  - Mispredict is head.pred != resolve_taken. On mispredict, next cycle:
    - flush=1;
    - redirect_pc = resolve_target if taken, else head.pc+4 (64-bit wrap);
    - stat_mispredicts increments;
    - queue cleared, since all younger entries are wrong-path;
    - FSM enters FLUSH.
  - Resolve while empty: no table or stat change, err_underflow set, no flush.
- Simultaneous events:
  - Push and correct-resolve in the same cycle: both take effect and count is unchanged; legal when full.
  - Push and mispredicting resolve in the same cycle: push dropped; queue empty next cycle.
  - Lookup and update to the same index in the same cycle: lookup_taken shows the pre-update value; the update is visible next cycle.
- Latency: flush/redirect one cycle after resolve_valid. Counter update is visible to lookup one cycle after resolve.
- Stats saturate at all-ones and do not wrap.

Test Plan:
- Reset, wait 64 cycles → push_ready rises on cycle 64. lookup_taken=0 for every pc. q_count=0.
- Push pc=0x40, pred=0; resolve taken=1, target=0x100 → next cycle flush=1, redirect_pc=0x100, stat_mispredicts=1. Counter at idx 0x10 becomes 2'b10, so lookup_taken(0x40)=1.
- Push pc=0x80, pred=1; resolve taken=0 → redirect_pc=0x84, flush for exactly one cycle. A push in the FLUSH cycle is ignored; q_count=0.
- 4 pushes then a 5th with push_valid=1 → push_ready=0, err_overflow=1, q_count=4. 4 correct resolves → q_count=0 and no flush.
- Resolve with queue empty → err_underflow=1, stats unchanged. Three taken resolves at pc=0x40 → counter saturates at 2'b11; a 4th stays at 11.
- Same-cycle push (pc=0x200) and mispredicting resolve → queue empty next cycle. Same-cycle lookup and update at 0x40 returns the old value.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: keeps an in-order queue of predicted branches from ID,
// resolves the oldest one from MEM, trains a table of 2-bit saturating counters
// and issues a one-cycle flush/redirect to fetch on a misprediction.
module branch_resolution_unit #(
   parameter int INDEX_BITS  = 6,
   parameter int QUEUE_DEPTH = 4,
   parameter int CNT_W       = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [63:0]                    lookup_pc,
   output logic                           lookup_taken,
   input  logic                           push_valid,
   output logic                           push_ready,
   input  logic [63:0]                    push_pc,
   input  logic                           push_pred,
   input  logic                           resolve_valid,
   input  logic                           resolve_taken,
   input  logic [63:0]                    resolve_target,
   output logic                           flush,
   output logic [63:0]                    redirect_pc,
   output logic [$clog2(QUEUE_DEPTH):0]   q_count,
   output logic                           err_overflow,
   output logic                           err_underflow,
   output logic [CNT_W-1:0]               stat_branches,
   output logic [CNT_W-1:0]               stat_mispredicts
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int PTR_W   = $clog2(QUEUE_DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = QUEUE_DEPTH[PTR_W:0];

   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

   state_t                  stateReg, stateNext;
   logic [INDEX_BITS-1:0]   initIdxReg;
   logic [1:0]              ctrTable [ENTRIES];

   logic [63:0]             pcQ   [QUEUE_DEPTH];
   logic                    predQ [QUEUE_DEPTH];
   logic [PTR_W-1:0]        headReg, tailReg;
   logic [PTR_W:0]          countReg;

   logic                    flushReg, errOverflowReg, errUnderflowReg;
   logic [63:0]             redirectReg;
   logic [CNT_W-1:0]        statBranchesReg, statMispredictsReg;

   logic                    active, qEmpty, qFull;
   logic                    resolveFire, underflowEv, mispredict, correctPop;
   logic                    pushAllowed, pushFire, overflowEv;
   logic [63:0]             headPc;
   logic                    headPred;
   logic [INDEX_BITS-1:0]   updIdx, lookupIdx;
   logic [1:0]              curCtr, nextCtr;
   logic                    unusedLookupBits;

   // Event decode: what the queue, table and statistics do this cycle
   always_comb begin
      active      = (stateReg != ST_INIT);
      qEmpty      = (countReg == '0);
      qFull       = (countReg == FULL_COUNT);
      headPc      = pcQ[headReg];
      headPred    = predQ[headReg];
      resolveFire = resolve_valid && active && !qEmpty;
      underflowEv = resolve_valid && active && qEmpty;
      mispredict  = resolveFire && (headPred != resolve_taken);
      correctPop  = resolveFire && !mispredict;
      // A correct pop frees a slot, so a push into a full queue is legal then;
      // a push alongside a mispredict is wrong-path and silently dropped.
      pushAllowed = push_valid && (stateReg == ST_RUN) && !mispredict;
      pushFire    = pushAllowed && (!qFull || correctPop);
      overflowEv  = pushAllowed && qFull && !correctPop;
      updIdx      = headPc[INDEX_BITS+1:2];
      lookupIdx   = lookup_pc[INDEX_BITS+1:2];
      curCtr      = ctrTable[updIdx];
      if (resolve_taken) begin
         nextCtr = (curCtr == 2'b11) ? 2'b11 : curCtr + 2'b01;
      end else begin
         nextCtr = (curCtr == 2'b00) ? 2'b00 : curCtr - 2'b01;
      end
   end

   // Next-state logic: sweep the table once, then run; one flush cycle per mispredict
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         ST_INIT:  if (&initIdxReg) stateNext = ST_RUN;
         ST_RUN:   if (mispredict) stateNext = ST_FLUSH;
         ST_FLUSH: stateNext = mispredict ? ST_FLUSH : ST_RUN;
         default:  stateNext = ST_INIT;
      endcase
   end

   // State register and init sweep index
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg   <= ST_INIT;
         initIdxReg <= '0;
      end else begin
         stateReg <= stateNext;
         if (stateReg == ST_INIT) initIdxReg <= initIdxReg + 1'b1;
      end
   end

   // Counter table: written to weakly-not-taken during the sweep, trained on resolve
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (stateReg == ST_INIT) begin
            ctrTable[initIdxReg] <= 2'b01;
         end else if (resolveFire) begin
            ctrTable[updIdx] <= nextCtr;
         end
      end
   end

   // Queue payload storage; pointers are handled separately so data needs no reset
   always_ff @(posedge clk) begin
      if (pushFire) begin
         pcQ[tailReg]   <= push_pc;
         predQ[tailReg] <= push_pred;
      end
   end

   // Queue pointers and occupancy; a mispredict drops every younger entry
   always_ff @(posedge clk) begin
      if (reset || mispredict) begin
         headReg  <= '0;
         tailReg  <= '0;
         countReg <= '0;
      end else begin
         if (correctPop) headReg <= headReg + 1'b1;
         if (pushFire)   tailReg <= tailReg + 1'b1;
         case ({pushFire, correctPop})
            2'b10:   countReg <= countReg + 1'b1;
            2'b01:   countReg <= countReg - 1'b1;
            default: countReg <= countReg;
         endcase
      end
   end

   // Flush/redirect pulse, sticky error flags and saturating statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         flushReg           <= 1'b0;
         redirectReg        <= '0;
         errOverflowReg     <= 1'b0;
         errUnderflowReg    <= 1'b0;
         statBranchesReg    <= '0;
         statMispredictsReg <= '0;
      end else begin
         flushReg <= mispredict;
         if (mispredict) begin
            redirectReg <= resolve_taken ? resolve_target : headPc + 64'd4;
            if (!(&statMispredictsReg)) statMispredictsReg <= statMispredictsReg + 1'b1;
         end
         if (resolveFire && !(&statBranchesReg)) statBranchesReg <= statBranchesReg + 1'b1;
         if (overflowEv)  errOverflowReg  <= 1'b1;
         if (underflowEv) errUnderflowReg <= 1'b1;
      end
   end

   assign unusedLookupBits = ^{lookup_pc[63:INDEX_BITS+2], lookup_pc[1:0]};

   assign lookup_taken     = active && ctrTable[lookupIdx][1];
   assign push_ready       = active && !qFull;
   assign flush            = flushReg;
   assign redirect_pc      = redirectReg;
   assign q_count          = countReg;
   assign err_overflow     = errOverflowReg;
   assign err_underflow    = errUnderflowReg;
   assign stat_branches    = statBranchesReg;
   assign stat_mispredicts = statMispredictsReg;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Testbench for branch_resolution_unit: directed scenarios followed by random
// traffic, every cycle compared against a queue/array reference model.
module tb_branch_resolution_unit;

   localparam int DEPTH   = 4;
   localparam int ENTRIES = 64;

   logic        clk;
   logic        reset;
   logic [63:0] lookup_pc;
   logic        lookup_taken;
   logic        push_valid;
   logic        push_ready;
   logic [63:0] push_pc;
   logic        push_pred;
   logic        resolve_valid;
   logic        resolve_taken;
   logic [63:0] resolve_target;
   logic        flush;
   logic [63:0] redirect_pc;
   logic [2:0]  q_count;
   logic        err_overflow;
   logic        err_underflow;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   branch_resolution_unit #(.INDEX_BITS(6), .QUEUE_DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_pc(push_pc), .push_pred(push_pred),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_target(resolve_target),
      .flush(flush), .redirect_pc(redirect_pc), .q_count(q_count),
      .err_overflow(err_overflow), .err_underflow(err_underflow),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   typedef struct {
      logic [63:0] pc;
      bit          pred;
   } rec_t;

   rec_t        mq[$];
   int          mctr[ENTRIES];
   int          initLeft;
   bit          inFlushM;
   bit          eFlush, eOv, eUn;
   logic [63:0] eRedirect;
   logic [31:0] eBr, eMis;
   bit          known;

   int total = 0;
   int bad   = 0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int idxOf(input logic [63:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   task automatic modelStep(input bit rst, input bit pv, input logic [63:0] ppc, input bit ppred,
                            input bit rv, input bit rt, input logic [63:0] rtgt);
      bit   mis;
      rec_t h;
      rec_t n;
      mis = 0;
      if (rst) begin
         initLeft  = ENTRIES;
         mq.delete();
         inFlushM  = 0;
         eFlush    = 0;
         eRedirect = '0;
         eOv       = 0;
         eUn       = 0;
         eBr       = '0;
         eMis      = '0;
         for (int i = 0; i < ENTRIES; i++) mctr[i] = 1;
      end else if (initLeft > 0) begin
         initLeft--;
         eFlush = 0;
      end else begin
         if (rv) begin
            if (mq.size() == 0) begin
               eUn = 1;
            end else begin
               h = mq.pop_front();
               if (rt) mctr[idxOf(h.pc)] = (mctr[idxOf(h.pc)] >= 3) ? 3 : mctr[idxOf(h.pc)] + 1;
               else    mctr[idxOf(h.pc)] = (mctr[idxOf(h.pc)] <= 0) ? 0 : mctr[idxOf(h.pc)] - 1;
               if (eBr != 32'hFFFF_FFFF) eBr++;
               mis = (h.pred != rt);
               $display("resolve pc=%h pred=%0d taken=%0d mispredict=%0d", h.pc, h.pred, rt, mis);
            end
         end
         if (pv && !inFlushM && !mis) begin
            if (mq.size() < DEPTH) begin
               n.pc   = ppc;
               n.pred = ppred;
               mq.push_back(n);
            end else begin
               eOv = 1;
            end
         end
         if (mis) begin
            mq.delete();
            eFlush    = 1;
            eRedirect = rt ? rtgt : h.pc + 64'd4;
            if (eMis != 32'hFFFF_FFFF) eMis++;
            inFlushM  = 1;
         end else begin
            eFlush   = 0;
            inFlushM = 0;
         end
      end
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, advance the
   // model, then check registered outputs just after the rising edge.
   task automatic cycle(input bit rst, input bit pv, input logic [63:0] ppc, input bit ppred,
                        input bit rv, input bit rt, input logic [63:0] rtgt, input logic [63:0] lpc);
      @(negedge clk);
      reset          = rst;
      push_valid     = pv;
      push_pc        = ppc;
      push_pred      = ppred;
      resolve_valid  = rv;
      resolve_taken  = rt;
      resolve_target = rtgt;
      lookup_pc      = lpc;
      #1;
      if (known) begin
         checkVal("lookup_taken", 64'(lookup_taken), 64'(initLeft == 0 && mctr[idxOf(lpc)] >= 2));
         checkVal("push_ready", 64'(push_ready), 64'(initLeft == 0 && mq.size() < DEPTH));
      end
      modelStep(rst, pv, ppc, ppred, rv, rt, rtgt);
      @(posedge clk);
      #1;
      known = 1;
      checkVal("q_count", 64'(q_count), 64'(mq.size()));
      checkVal("flush", 64'(flush), 64'(eFlush));
      checkVal("redirect_pc", redirect_pc, eRedirect);
      checkVal("err_overflow", 64'(err_overflow), 64'(eOv));
      checkVal("err_underflow", 64'(err_underflow), 64'(eUn));
      checkVal("stat_branches", 64'(stat_branches), 64'(eBr));
      checkVal("stat_mispredicts", 64'(stat_mispredicts), 64'(eMis));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, 0, '0, {$urandom, $urandom});
   endtask

   task automatic push(input logic [63:0] pc, input bit pred);
      cycle(0, 1, pc, pred, 0, 0, '0, pc);
   endtask

   task automatic resolve(input bit taken, input logic [63:0] tgt);
      cycle(0, 0, '0, 0, 1, taken, tgt, 64'h40);
   endtask

   task automatic peekLookup(input string tag, input logic [63:0] pc, input bit exp);
      lookup_pc = pc;
      #1;
      checkVal(tag, 64'(lookup_taken), 64'(exp));
   endtask

   function automatic logic [63:0] pickPc();
      case ($urandom_range(0, 4))
         0:       return 64'h40;
         1:       return 64'h80;
         2:       return 64'h200;
         3:       return 64'h1000 + 64'($urandom_range(0, 7) * 4);
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      known          = 0;
      initLeft       = ENTRIES;
      reset          = 1;
      push_valid     = 0;
      push_pc        = '0;
      push_pred      = 0;
      resolve_valid  = 0;
      resolve_taken  = 0;
      resolve_target = '0;
      lookup_pc      = '0;

      // Reset and table sweep
      cycle(1, 0, '0, 0, 0, 0, '0, '0);
      cycle(1, 1, 64'h40, 0, 1, 1, 64'h100, 64'h40);
      idle(63);
      checkVal("init_ready_low", 64'(push_ready), 64'd0);
      idle(1);
      checkVal("init_ready_high", 64'(push_ready), 64'd1);
      checkVal("init_q_count", 64'(q_count), 64'd0);

      // Taken mispredict trains idx 0x10 to weakly taken
      push(64'h40, 0);
      resolve(1, 64'h100);
      checkVal("mp_taken_flush", 64'(flush), 64'd1);
      checkVal("mp_taken_redirect", redirect_pc, 64'h100);
      checkVal("mp_taken_stat", 64'(stat_mispredicts), 64'd1);
      peekLookup("mp_taken_lookup", 64'h40, 1);
      idle(1);
      checkVal("mp_flush_single", 64'(flush), 64'd0);

      // Not-taken mispredict; push during the flush cycle is dropped
      push(64'h80, 1);
      resolve(0, 64'hDEAD_0000);
      checkVal("mp_nt_redirect", redirect_pc, 64'h84);
      push(64'h300, 1);
      checkVal("flush_push_drop", 64'(q_count), 64'd0);
      checkVal("flush_one_cycle", 64'(flush), 64'd0);

      // Fill, overflow, drain with correct predictions
      for (int i = 0; i < DEPTH; i++) push(64'h1000 + 64'(i * 16), i[0]);
      checkVal("full_ready", 64'(push_ready), 64'd0);
      push(64'h2000, 1);
      checkVal("overflow_flag", 64'(err_overflow), 64'd1);
      checkVal("overflow_count", 64'(q_count), 64'd4);
      for (int i = 0; i < DEPTH; i++) resolve(i[0], 64'h3000);
      checkVal("drain_count", 64'(q_count), 64'd0);
      checkVal("drain_no_flush", 64'(flush), 64'd0);

      // Underflow, then saturation at idx 0x10
      resolve(1, 64'h500);
      checkVal("underflow_flag", 64'(err_underflow), 64'd1);
      checkVal("underflow_stats", 64'(stat_branches), 64'd6);
      for (int i = 0; i < 4; i++) begin
         push(64'h40, 1);
         resolve(1, 64'h500);
      end
      push(64'h40, 0);
      resolve(0, 64'h500);
      peekLookup("sat_one_down", 64'h40, 1);

      // Push alongside a mispredicting resolve, lookup of the same index
      push(64'h40, 1);
      cycle(0, 1, 64'h200, 0, 1, 0, 64'h600, 64'h40);
      checkVal("mp_push_drop", 64'(q_count), 64'd0);
      peekLookup("post_update_lookup", 64'h40, 0);
      idle(2);

      // Random traffic with one reset mid-run
      for (int i = 0; i < 1500; i++) begin
         cycle(i == 700,
               $urandom_range(0, 99) < 55, pickPc(), 1'($urandom),
               $urandom_range(0, 99) < 45, 1'($urandom), {$urandom, $urandom},
               pickPc());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
